// File: rtl/set_pkg.sv
// rtl/set_pkg.sv - shared types and constants for the SET command scheduler
//
// Purpose:
//   State encoding of the scheduler FSM, layout of one queued command
//   and the default response timeout. Imported by set_cmd_fifo and
//   set_scheduler.
//
// Contents:
//   state_t          IDLE / ISSUE / WAIT / HOLD
//   cmd_t            packed command entry {tag, central, radius, mode}
//   ENTRY_W          width of one queue entry (42 bits)
//   DEFAULT_TIMEOUT  default cycle budget for SET to answer
package set_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]  tag;
        logic [23:0] central;
        logic [11:0] radius;
        logic [1:0]  mode;
    } cmd_t;

    localparam int ENTRY_W         = 42;
    localparam int DEFAULT_TIMEOUT = 128;

endpackage

// File: rtl/set_cmd_fifo.sv
// rtl/set_cmd_fifo.sv - synchronous command queue in front of the SET scheduler
//
// Purpose:
//   DEPTH-entry FIFO, written and read on the rising clock edge. The head
//   entry is presented combinationally so the scheduler can latch it in
//   the same cycle it pops.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset (pointers only)
//   push           write request; ignored while full
//   push_data      entry to write at the tail
//   pop            read request; ignored while empty
//   head           entry currently at the head
//   full, empty    occupancy flags
module set_cmd_fifo
    import set_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit: equal indices with differing MSBs means full.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push on a full queue is dropped even if a pop frees a slot in the
    // same cycle; the producer only ever sees cmd_ready derived from full.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/set_scheduler.sv
// rtl/set_scheduler.sv - queues SET commands, issues them one at a time, returns tagged results
//
// Purpose:
//   Accepts commands into a FIFO, issues each to the downstream SET engine
//   with a one-cycle en pulse, waits for SET's valid (or a timeout) and
//   holds the tagged result until the consumer takes it. Results come back
//   in command order, one per accepted command.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = queue not full)
//   cmd_tag                   command ID echoed on res_tag
//   cmd_central/radius/mode   command payload
//   en                        one-cycle start pulse to SET
//   central/radius/mode       payload to SET, held after issue
//   busy, valid, candidate    status and answer from SET
//   res_valid/res_ready       result handshake
//   res_tag/res_candidate     result payload
//   res_timeout               1 when SET did not answer in time
//   idle                      queue empty and FSM in IDLE
module set_scheduler
    import set_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_tag,
    input  logic [23:0] cmd_central,
    input  logic [11:0] cmd_radius,
    input  logic [1:0]  cmd_mode,
    output logic        en,
    output logic [23:0] central,
    output logic [11:0] radius,
    output logic [1:0]  mode,
    input  logic        busy,
    input  logic        valid,
    input  logic [7:0]  candidate,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_tag,
    output logic [7:0]  res_candidate,
    output logic        res_timeout,
    output logic        idle
);

    localparam int               CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [3:0]         cur_tag;

    cmd_t               push_entry;
    cmd_t               head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    assign push_entry = {cmd_tag, cmd_central, cmd_radius, cmd_mode};
    assign head_entry = cmd_t'(head_bits);

    // Pop only when SET reports not busy, so the next en never lands on
    // an engine still finishing the previous job.
    assign fifo_pop = (state == IDLE) && !fifo_empty && !busy;

    assign cmd_ready = !fifo_full;
    assign idle      = fifo_empty && (state == IDLE);

    set_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            cur_tag       <= '0;
            en            <= 1'b0;
            central       <= '0;
            radius        <= '0;
            mode          <= '0;
            res_valid     <= 1'b0;
            res_tag       <= '0;
            res_candidate <= '0;
            res_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        cur_tag <= head_entry.tag;
                        central <= head_entry.central;
                        radius  <= head_entry.radius;
                        mode    <= head_entry.mode;
                        en      <= 1'b1;
                        state   <= ISSUE;
                    end
                end

                ISSUE: begin
                    en       <= 1'b0;
                    wait_cnt <= CNT_W'(1);
                    state    <= WAIT;
                end

                WAIT: begin
                    // valid is tested first so an answer arriving on the
                    // last allowed cycle is reported as a real result.
                    if (valid) begin
                        res_candidate <= candidate;
                        res_timeout   <= 1'b0;
                        res_tag       <= cur_tag;
                        res_valid     <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= HOLD;
                    end else if (wait_cnt >= TIMEOUT_VAL) begin
                        res_candidate <= '0;
                        res_timeout   <= 1'b1;
                        res_tag       <= cur_tag;
                        res_valid     <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= HOLD;
                    end else begin
                        // Only reached below TIMEOUT_VAL, so the count
                        // saturates at the limit rather than wrapping.
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    // res_valid is a register, so res_ready only affects
                    // it on the following edge.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
